// File: rtl/triggered_pulse_train.sv
`default_nettype none
// ============================================================================
// Module   : triggered_pulse_train
// Purpose  : On an accepted trigger, waits D clock-enables, then emits N
//            pulses of toggle data (T enables each) separated by G enables
//            of idle data. Timing config is latched when a trigger is
//            accepted. Supports abort, optional retrigger and status outputs.
// Options  : TRIGGERED_PULSE_TRAIN_TRIG_EDGE_EN -- defined: rising edge of
//            trig_i (sampled on ce clocks) triggers; undefined: level.
// Revision : 1.0 - initial release
// ============================================================================
module triggered_pulse_train #(
    parameter int COUNTER_WIDTH   = 18,
    parameter int DATA_WIDTH      = 14,
    parameter int PULSE_CNT_WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       ce_i,
    input  logic                       trig_i,
    input  logic                       abort_i,
    input  logic                       retrig_en_i,
    input  logic [DATA_WIDTH-1:0]      idle_data_i,
    input  logic [DATA_WIDTH-1:0]      toggle_data_i,
    input  logic [COUNTER_WIDTH-1:0]   delay_cycles_i,
    input  logic [COUNTER_WIDTH-1:0]   toggle_cycles_i,
    input  logic [COUNTER_WIDTH-1:0]   gap_cycles_i,
    input  logic [PULSE_CNT_WIDTH-1:0] n_pulses_i,
    output logic [DATA_WIDTH-1:0]      data_o,
    output logic                       busy_o,
    output logic                       active_o,
    output logic                       done_o,
    output logic [PULSE_CNT_WIDTH-1:0] pulse_count_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_ON    = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam logic [COUNTER_WIDTH-1:0]   c_cnt_one = COUNTER_WIDTH'(1);
    localparam logic [PULSE_CNT_WIDTH-1:0] c_pc_one  = PULSE_CNT_WIDTH'(1);

    // Registered state. The delay value is only needed at trigger time, so
    // only T, G and N are kept in shadows.
    state_t                     r_state;
    logic [COUNTER_WIDTH-1:0]   r_cnt;
    logic [COUNTER_WIDTH-1:0]   r_toggle_sh;
    logic [COUNTER_WIDTH-1:0]   r_gap_sh;
    logic [PULSE_CNT_WIDTH-1:0] r_npulse_sh;
    logic [DATA_WIDTH-1:0]      r_data;
    logic                       r_busy;
    logic                       r_active;
    logic                       r_done;
    logic [PULSE_CNT_WIDTH-1:0] r_pulse_count;

    // Next-state values.
    state_t                     w_state_nxt;
    logic [COUNTER_WIDTH-1:0]   w_cnt_nxt;
    logic [COUNTER_WIDTH-1:0]   w_toggle_sh_nxt;
    logic [COUNTER_WIDTH-1:0]   w_gap_sh_nxt;
    logic [PULSE_CNT_WIDTH-1:0] w_npulse_sh_nxt;
    logic [DATA_WIDTH-1:0]      w_data_nxt;
    logic                       w_busy_nxt;
    logic                       w_active_nxt;
    logic                       w_done_nxt;
    logic [PULSE_CNT_WIDTH-1:0] w_pulse_count_nxt;

    // Helper terms.
    logic                       w_trig_event;
    logic                       w_cfg_valid;
    logic                       w_trig_accept;
    logic [COUNTER_WIDTH-1:0]   w_start_cnt;
    logic [COUNTER_WIDTH-1:0]   w_reload_on;
    logic [COUNTER_WIDTH-1:0]   w_reload_gap;
    logic [COUNTER_WIDTH-1:0]   w_cnt_dec;
    logic [PULSE_CNT_WIDTH-1:0] w_count_inc;

`ifdef TRIGGERED_PULSE_TRAIN_TRIG_EDGE_EN
    logic r_trig_prev;

    // Previous trigger level as seen on ce clocks, for rising-edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_trig_prev <= 1'b0;
        end else if (ce_i) begin
            r_trig_prev <= trig_i;
        end
    end

    assign w_trig_event = trig_i & ~r_trig_prev;
`else
    assign w_trig_event = trig_i;
`endif

    // A trigger with zero pulse length or zero pulse count is not a train.
    assign w_cfg_valid   = (toggle_cycles_i != '0) && (n_pulses_i != '0);
    assign w_trig_accept = w_trig_event && w_cfg_valid &&
                           ((r_state == S_IDLE) || retrig_en_i);

    // Counters hold "remaining enables minus one", so each phase of length L
    // lasts exactly L enables. Subtractions are guarded against zero.
    assign w_start_cnt  = (delay_cycles_i != '0) ? (delay_cycles_i - c_cnt_one)
                                                 : (toggle_cycles_i - c_cnt_one);
    assign w_reload_on  = r_toggle_sh - c_cnt_one;
    assign w_reload_gap = r_gap_sh - c_cnt_one;
    assign w_cnt_dec    = r_cnt - c_cnt_one;
    assign w_count_inc  = r_pulse_count + c_pc_one;

    // Next-state and next-output logic; outputs reflect the state the
    // sequencer was in on the updating clock.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_toggle_sh_nxt   = r_toggle_sh;
        w_gap_sh_nxt      = r_gap_sh;
        w_npulse_sh_nxt   = r_npulse_sh;
        w_data_nxt        = r_data;
        w_busy_nxt        = r_busy;
        w_active_nxt      = r_active;
        w_done_nxt        = 1'b0;
        w_pulse_count_nxt = r_pulse_count;

        if (abort_i) begin
            // Abort acts on any clock and overrides trigger and completion.
            w_state_nxt  = S_IDLE;
            w_cnt_nxt    = '0;
            w_data_nxt   = idle_data_i;
            w_busy_nxt   = 1'b0;
            w_active_nxt = 1'b0;
        end else if (ce_i) begin
            w_data_nxt   = (r_state == S_ON) ? toggle_data_i : idle_data_i;
            w_busy_nxt   = (r_state != S_IDLE);
            w_active_nxt = (r_state == S_ON);

            if (w_trig_accept) begin
                // Fresh start or retrigger: identical handling, data idle.
                w_toggle_sh_nxt   = toggle_cycles_i;
                w_gap_sh_nxt      = gap_cycles_i;
                w_npulse_sh_nxt   = n_pulses_i;
                w_pulse_count_nxt = '0;
                w_cnt_nxt         = w_start_cnt;
                w_state_nxt       = (delay_cycles_i != '0) ? S_DELAY : S_ON;
                w_data_nxt        = idle_data_i;
                w_active_nxt      = 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        w_cnt_nxt = '0;
                    end
                    S_DELAY, S_GAP: begin
                        if (r_cnt == '0) begin
                            w_state_nxt = S_ON;
                            w_cnt_nxt   = w_reload_on;
                        end else begin
                            w_cnt_nxt = w_cnt_dec;
                        end
                    end
                    S_ON: begin
                        if (r_cnt == '0) begin
                            w_pulse_count_nxt = w_count_inc;
                            if (w_count_inc == r_npulse_sh) begin
                                w_state_nxt = S_IDLE;
                                w_cnt_nxt   = '0;
                                w_done_nxt  = 1'b1;
                            end else if (r_gap_sh == '0) begin
                                w_cnt_nxt = w_reload_on;
                            end else begin
                                w_state_nxt = S_GAP;
                                w_cnt_nxt   = w_reload_gap;
                            end
                        end else begin
                            w_cnt_nxt = w_cnt_dec;
                        end
                    end
                    default: begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end
                endcase
            end
        end
    end

    // State, counter, shadow and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_toggle_sh   <= '0;
            r_gap_sh      <= '0;
            r_npulse_sh   <= '0;
            r_data        <= '0;
            r_busy        <= 1'b0;
            r_active      <= 1'b0;
            r_done        <= 1'b0;
            r_pulse_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_toggle_sh   <= w_toggle_sh_nxt;
            r_gap_sh      <= w_gap_sh_nxt;
            r_npulse_sh   <= w_npulse_sh_nxt;
            r_data        <= w_data_nxt;
            r_busy        <= w_busy_nxt;
            r_active      <= w_active_nxt;
            r_done        <= w_done_nxt;
            r_pulse_count <= w_pulse_count_nxt;
        end
    end

    assign data_o        = r_data;
    assign busy_o        = r_busy;
    assign active_o      = r_active;
    assign done_o        = r_done;
    assign pulse_count_o = r_pulse_count;

endmodule
`default_nettype wire

// File: tb/tb_triggered_pulse_train.sv
`default_nettype none
// ============================================================================
// Module   : tb_triggered_pulse_train
// Purpose  : Self-checking bench for triggered_pulse_train. Expected output
//            words are queued as stimulus is driven and compared per clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_triggered_pulse_train;

    localparam int CW = 18;
    localparam int DW = 14;
    localparam int PW = 8;
    localparam logic [DW-1:0] c_idle = 14'h00AA;
    localparam logic [DW-1:0] c_tog  = 14'h3F55;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ce = 1'b1;
    logic          trig = 1'b0;
    logic          abort = 1'b0;
    logic          retrig_en = 1'b0;
    logic [DW-1:0] idle_d = c_idle;
    logic [DW-1:0] tog_d = c_tog;
    logic [CW-1:0] dly = '0;
    logic [CW-1:0] tgl = '0;
    logic [CW-1:0] gap = '0;
    logic [PW-1:0] np = '0;

    logic [DW-1:0] data_o;
    logic          busy_o;
    logic          active_o;
    logic          done_o;
    logic [PW-1:0] pulse_count_o;

    // Observed word: {data, busy, active, done, pulse_count}
    logic [24:0] w_obs;
    assign w_obs = {data_o, busy_o, active_o, done_o, pulse_count_o};

    int          checks = 0;
    int          failures = 0;
    logic [24:0] sb[$];

    always #5 clk = ~clk;

    triggered_pulse_train #(
        .COUNTER_WIDTH  (CW),
        .DATA_WIDTH     (DW),
        .PULSE_CNT_WIDTH(PW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .ce_i           (ce),
        .trig_i         (trig),
        .abort_i        (abort),
        .retrig_en_i    (retrig_en),
        .idle_data_i    (idle_d),
        .toggle_data_i  (tog_d),
        .delay_cycles_i (dly),
        .toggle_cycles_i(tgl),
        .gap_cycles_i   (gap),
        .n_pulses_i     (np),
        .data_o         (data_o),
        .busy_o         (busy_o),
        .active_o       (active_o),
        .done_o         (done_o),
        .pulse_count_o  (pulse_count_o)
    );

    // Closed-form expectation for clock k after a trigger at clock 0 (ce=1).
    function automatic logic [24:0] exp_at(input int k, input int d, input int t,
                                           input int g, input int n);
        int   cnt;
        int   done_clk;
        int   s;
        int   e;
        logic on;
        cnt = 0;
        on = 1'b0;
        done_clk = d + n * t + (n - 1) * g;
        for (int i = 0; i < n; i++) begin
            s = d + 1 + i * (t + g);
            e = d + i * (t + g) + t;
            if (k >= s && k <= e) on = 1'b1;
            if (k >= e) cnt++;
        end
        return {(on ? c_tog : c_idle), (k >= 1 && k <= done_clk), on,
                (k == done_clk), PW'(cnt)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int d, input int t, input int g, input int n);
        dly = CW'(d);
        tgl = CW'(t);
        gap = CW'(g);
        np  = PW'(n);
    endtask

    task automatic test_reset();
        logic [24:0] e;
        rst_n = 1'b0;
        repeat (3) tick();
        e = '0;
        checks++;
        if (w_obs !== e) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=%h", w_obs, e);
        end
        rst_n = 1'b1;
        tick();
        e = {c_idle, 1'b0, 1'b0, 1'b0, 8'd0};
        checks++;
        if (w_obs !== e) begin
            failures++;
            $display("FAIL reset_release got=%h exp=%h", w_obs, e);
        end
    endtask

    // Generic single train at ce=1 with a one-clock trigger.
    task automatic test_train(input string name, input int d, input int t,
                              input int g, input int n, input int len);
        logic [24:0] e;
        set_cfg(d, t, g, n);
        for (int k = 1; k <= len; k++) sb.push_back(exp_at(k, d, t, g, n));
        trig = 1'b1;
        tick();
        trig = 1'b0;
        for (int k = 1; k <= len; k++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if (w_obs !== e) begin
                failures++;
                $display("FAIL %s clk=%0d got=%h exp=%h", name, k, w_obs, e);
            end
        end
    endtask

    task automatic test_ignored(input logic [PW-1:0] held_cnt);
        logic [24:0] e;
        for (int r = 0; r < 2; r++) begin
            if (r == 0) set_cfg(3, 0, 1, 3);
            else        set_cfg(3, 2, 1, 0);
            for (int k = 1; k <= 5; k++) sb.push_back({c_idle, 1'b0, 1'b0, 1'b0, held_cnt});
            trig = 1'b1;
            tick();
            trig = 1'b0;
            for (int k = 1; k <= 5; k++) begin
                tick();
                e = sb.pop_front();
                checks++;
                if (w_obs !== e) begin
                    failures++;
                    $display("FAIL ignored r=%0d clk=%0d got=%h exp=%h", r, k, w_obs, e);
                end
            end
        end
    endtask

    // ce every 4th clock, D=1 T=1 N=1; T changed mid-train must not matter.
    task automatic test_ce_div();
        logic [24:0] e;
        logic        on;
        set_cfg(1, 1, 0, 1);
        for (int j = 1; j <= 15; j++) begin
            on = (j >= 8 && j <= 11);
            sb.push_back({(on ? c_tog : c_idle), (j >= 4 && j <= 11), on,
                          (j == 8), ((j >= 8) ? 8'd1 : 8'd0)});
        end
        for (int j = 0; j <= 15; j++) begin
            ce   = (j % 4 == 0);
            trig = (j == 0);
            if (j == 5) tgl = CW'(7);
            tick();
            if (j >= 1) begin
                e = sb.pop_front();
                checks++;
                if (w_obs !== e) begin
                    failures++;
                    $display("FAIL ce_div clk=%0d got=%h exp=%h", j, w_obs, e);
                end
            end
        end
        ce = 1'b1;
        trig = 1'b0;
    endtask

    // Abort on clock 7, the first clock the second pulse is in ON.
    task automatic test_abort();
        logic [24:0] e;
        set_cfg(3, 2, 1, 3);
        for (int k = 1; k <= 6; k++) sb.push_back(exp_at(k, 3, 2, 1, 3));
        for (int k = 7; k <= 12; k++) sb.push_back({c_idle, 1'b0, 1'b0, 1'b0, 8'd1});
        trig = 1'b1;
        tick();
        trig = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            abort = (k == 7);
            tick();
            e = sb.pop_front();
            checks++;
            if (w_obs !== e) begin
                failures++;
                $display("FAIL abort clk=%0d got=%h exp=%h", k, w_obs, e);
            end
        end
        abort = 1'b0;
    endtask

    // Trigger during GAP (clock 6): restarts with new config when enabled,
    // ignored (old config continues) when disabled.
    task automatic test_retrig(input logic en);
        logic [24:0] e;
        retrig_en = en;
        set_cfg(3, 2, 1, 3);
        for (int k = 1; k <= 16; k++) begin
            if (!en || k <= 5) sb.push_back(exp_at(k, 3, 2, 1, 3));
            else if (k == 6)   sb.push_back({c_idle, 1'b1, 1'b0, 1'b0, 8'd0});
            else               sb.push_back(exp_at(k - 6, 1, 1, 1, 2));
        end
        trig = 1'b1;
        tick();
        trig = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            if (k == 6) begin
                set_cfg(1, 1, 1, 2);
                trig = 1'b1;
            end else begin
                trig = 1'b0;
            end
            tick();
            e = sb.pop_front();
            checks++;
            if (w_obs !== e) begin
                failures++;
                $display("FAIL retrig_en%0d clk=%0d got=%h exp=%h", en, k, w_obs, e);
            end
        end
        trig = 1'b0;
        retrig_en = 1'b0;
    endtask

    // trig held high for 100 clocks with D=0 T=2 G=0 N=1.
    task automatic test_trig_hold();
        logic [24:0] e;
        int          r;
        set_cfg(0, 2, 0, 1);
        for (int k = 1; k <= 99; k++) begin
`ifdef TRIGGERED_PULSE_TRAIN_TRIG_EDGE_EN
            sb.push_back(exp_at(k, 0, 2, 0, 1));
`else
            r = k % 3;
            if (r == 0) sb.push_back({c_idle, 1'b0, 1'b0, 1'b0, 8'd0});
            else        sb.push_back(exp_at(r, 0, 2, 0, 1));
`endif
        end
        trig = 1'b1;
        tick();
        for (int k = 1; k <= 99; k++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if (w_obs !== e) begin
                failures++;
                $display("FAIL trig_hold clk=%0d got=%h exp=%h", k, w_obs, e);
            end
        end
        trig = 1'b0;
        repeat (5) tick();
    endtask

    // Reset asserted mid-pulse clears every output without waiting for a clock.
    task automatic test_reset_mid();
        logic [24:0] e;
        set_cfg(2, 4, 0, 1);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (4) tick();
        e = exp_at(4, 2, 4, 0, 1);
        checks++;
        if (w_obs !== e) begin
            failures++;
            $display("FAIL pre_reset_pulse got=%h exp=%h", w_obs, e);
        end
        rst_n = 1'b0;
        #1;
        e = '0;
        checks++;
        if (w_obs !== e) begin
            failures++;
            $display("FAIL reset_async got=%h exp=%h", w_obs, e);
        end
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        e = {c_idle, 1'b0, 1'b0, 1'b0, 8'd0};
        checks++;
        if (w_obs !== e) begin
            failures++;
            $display("FAIL post_reset_idle got=%h exp=%h", w_obs, e);
        end
    endtask

    initial begin
        test_reset();
        test_train("basic", 3, 2, 1, 3, 14);
        test_train("contiguous", 0, 4, 0, 2, 10);
        test_ignored(8'd2);
        test_ce_div();
        test_abort();
        test_retrig(1'b1);
        test_retrig(1'b0);
        test_trig_hold();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/triggered_pulse_train.md
Name: triggered_pulse_train

Overview:
- Parametrised successor to the single-shot triggered toggle.
- On a trigger, waits a delay, then outputs a train of N pulses. Each pulse is toggle data for T clock-enable pulses, separated by G enable pulses of idle data.
- Timing config is latched at trigger acceptance. Adds abort, optional retrigger, and status outputs.
- Sits between the feedback DAC-value path and the DAC output mux, driven by the same clock-enable divider.

Parameters:
COUNTER_WIDTH, 18, width of delay/toggle/gap counters.
DATA_WIDTH, 14, width of idle/toggle/output data.
PULSE_CNT_WIDTH, 8, width of pulse-count input and status.

Ports:
clk_i  in  1  system clock.
rst_ni  in  1  reset; one clock; reset is asynchronous and active-low.
ce_i  in  1  clock enable; all sequencing advances only on clocks with ce_i=1.
trig_i  in  1  trigger (level or edge, see Optional Feature).
abort_i  in  1  synchronous abort; acts on any clock, ce_i ignored.
retrig_en_i  in  1  1: trigger accepted while busy restarts the train.
idle_data_i  in  DATA_WIDTH  output value outside pulses.
toggle_data_i  in  DATA_WIDTH  output value during pulses.
delay_cycles_i  in  COUNTER_WIDTH  D, enable pulses before first pulse.
toggle_cycles_i  in  COUNTER_WIDTH  T, pulse length.
gap_cycles_i  in  COUNTER_WIDTH  G, spacing between pulses.
n_pulses_i  in  PULSE_CNT_WIDTH  N, pulses per train.
data_o  out  DATA_WIDTH  registered output data.
busy_o  out  1  registered; 1 when state != IDLE.
active_o  out  1  registered; 1 when state = ON.
done_o  out  1  one-clock pulse on normal train completion.
pulse_count_o  out  PULSE_CNT_WIDTH  completed pulses in current or last train.

Behaviour:
- Reset: data_o=0, busy_o=0, active_o=0, done_o=0, pulse_count_o=0, state IDLE, counters and shadows 0.
- States: IDLE, DELAY, ON, GAP. All outputs are registered. Unless stated otherwise, transitions and data updates occur only on ce_i=1 clocks.
- IDLE: data_o follows idle_data_i on each ce clock.
  - Accepted trigger: latch D/T/G/N into shadows; clear pulse_count_o.
  - D>0: go DELAY, counter=D-1.
  - D=0: go ON, counter=T-1.
- Ignored trigger: if T=0 or N=0, stay IDLE; no shadow load, no busy, no done_o.
- DELAY: data=idle. Decrement counter; at counter=0, go ON with counter=T-1.
- ON: data=toggle_data_i (live value). Decrement counter. At counter=0, increment pulse_count_o, then:
  - if count+1=N: go IDLE and pulse done_o;
  - else if G=0: reload ON with counter=T-1; output stays toggle contiguously;
  - else go GAP with counter=G-1.
- GAP: data=idle. Decrement counter; at 0, go ON with counter=T-1.
- Latency: first toggle data appears on data_o at the (D+1)th ce clock after the trigger ce clock. Each pulse spans exactly T ce clocks; each gap spans exactly G ce clocks.
- Config inputs changed mid-train have no effect until the next accepted trigger. Data inputs are sampled live.
- Retrigger, busy and retrig_en_i=1, trigger on a ce clock: behave exactly as a trigger accepted from IDLE (reload shadows, clear count, D rule). data=idle on that clock; done_o not pulsed.
- Retrigger with retrig_en_i=0: triggers while busy are ignored.
- Abort: abort_i=1 on any clock → next clock is IDLE, data_o=idle_data_i, counters cleared, done_o=0, pulse_count_o held.
  - Abort wins over a simultaneous trigger or completion.
- Counter arithmetic: unsigned, COUNTER_WIDTH bits. Maximum D/T/G = 2^COUNTER_WIDTH-1, with no wrap-around. N up to 2^PULSE_CNT_WIDTH-1.
- Invalid state encoding → IDLE on the next clock.

Optional Feature:
- Macro: TRIGGERED_PULSE_TRAIN_TRIG_EDGE_EN.
- Defined: trigger is the rising edge of trig_i as seen on ce clocks. The previous value is stored in a register updated on ce clocks and cleared by reset. A held-high trig_i gives one train only.
- Undefined: trigger is level-sensitive. trig_i=1 on a ce clock in IDLE is accepted, so a held-high trig_i re-arms immediately after each train.

Test Plan:
- ce_i=1 always, D=3, T=2, G=1, N=3, one-clock trig → data_o toggle on clocks 4-5, 7-8, 10-11 after trig; done_o on clock 11; pulse_count_o=3; busy_o low from clock 12.
- D=0, T=4, G=0, N=2 → toggle for 8 contiguous clocks starting clock 1; active_o high throughout; done_o once.
- T=0 or N=0 with trig → data_o stays idle, busy_o=0, done_o never asserted.
- ce_i every 4th clock, D=1, T=1, N=1 → toggle visible after the 2nd ce clock following trig, held 4 clocks; change T mid-train → no effect.
- Abort at the 2nd pulse's first ON clock → data_o=idle next clock, pulse_count_o=1, no done_o. Retrig with retrig_en_i=1 in GAP → count cleared, delay restarts; with retrig_en_i=0 → ignored.
- With TRIGGERED_PULSE_TRAIN_TRIG_EDGE_EN: trig held high 100 clocks, N=1, T=2 → exactly one pulse. Without the macro: pulses repeat. Assert rst_ni mid-pulse → all outputs 0 immediately.
